// File: rtl/load_store_unit.sv
// Load/store controller between EX/MEM and a word-addressed data memory.
// Handles lane extraction/extension for loads and sub-word stores via a two-cycle read-modify-write.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  mem_read_req_i,
  input  logic                  mem_write_req_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic                  stall_o
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state_q, state_d;
  logic [31:0] old_q, mask_q, wdata_q, addr_q;
  logic        capture;
  logic        bad_req;
  logic [4:0]  lane_shamt;
  logic [31:0] lane_mask, lane_wdata, aligned_addr;

  // Picks the addressed lane out of a memory word and extends it to 32 bits.
  function automatic logic [31:0] extend_lane(input logic [31:0] rdata, input logic [1:0] sz,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic [31:0]        r;
    b  = rdata[{off, 3'b000} +: 8];
    h  = off[1] ? rdata[31:16] : rdata[15:0];
    bs = signed'(b);
    hs = signed'(h);
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, b} : 32'(bs);
      SZ_HALF: r = uns ? {16'h0, h} : 32'(hs);
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign aligned_addr = {address_i[31:2], 2'b00};
  assign bad_req = (size_i == SZ_ILL)
                 || (size_i == SZ_HALF && address_i[0])
                 || (size_i == SZ_WORD && address_i[1:0] != 2'b00)
                 || (mem_read_req_i && mem_write_req_i);
  assign lane_shamt = (size_i == SZ_BYTE) ? {address_i[1:0], 3'b000} : {address_i[1], 4'b0000};
  assign lane_mask  = ((size_i == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shamt;
  assign lane_wdata = ((size_i == SZ_BYTE) ? {24'h0, store_data_i[7:0]}
                                           : {16'h0, store_data_i[15:0]}) << lane_shamt;

  // Outputs are forced low while reset is asserted, which also kills a pending MERGE write.
  always_comb begin
    state_d          = state_q;
    capture          = 1'b0;
    mem_address_o    = '0;
    mem_write_data_o = '0;
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    load_data_o      = '0;
    done_o           = 1'b0;
    fault_o          = 1'b0;
    stall_o          = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          mem_address_o = aligned_addr;
          if (req_valid_i) begin
            if (bad_req) begin
              fault_o = 1'b1;
            end else if (mem_read_req_i) begin
              mem_read_o  = 1'b1;
              done_o      = 1'b1;
              load_data_o = extend_lane(mem_read_data_i, size_i, address_i[1:0], unsigned_i);
            end else if (mem_write_req_i) begin
              if (size_i == SZ_WORD) begin
                mem_write_o      = 1'b1;
                mem_write_data_o = store_data_i;
                done_o           = 1'b1;
              end else begin
                mem_read_o = 1'b1;
                stall_o    = 1'b1;
                capture    = 1'b1;
                state_d    = MERGE;
              end
            end
          end
        end
        MERGE: begin
          mem_address_o    = addr_q;
          mem_write_data_o = (old_q & ~mask_q) | (wdata_q & mask_q);
          mem_write_o      = 1'b1;
          done_o           = 1'b1;
          state_d          = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      old_q   <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        old_q   <= mem_read_data_i;
        mask_q  <= lane_mask;
        wdata_q <= lane_wdata;
        addr_q  <= aligned_addr;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, mem_read_req_i, mem_write_req_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] address_i, store_data_i, mem_read_data_i;
  logic [31:0] mem_address_o, mem_write_data_o, load_data_o;
  logic        mem_write_o, mem_read_o, done_o, fault_o, stall_o;
  logic [31:0] mem [0:15];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i),
    .mem_read_req_i(mem_read_req_i), .mem_write_req_i(mem_write_req_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .address_i(address_i),
    .store_data_i(store_data_i), .mem_read_data_i(mem_read_data_i),
    .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .load_data_o(load_data_o),
    .done_o(done_o), .fault_o(fault_o), .stall_o(stall_o)
  );

  assign mem_read_data_i = mem[mem_address_o[5:2]];
  always @(posedge clk) if (mem_write_o) mem[mem_address_o[5:2]] <= mem_write_data_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1; mem_read_req_i = rd; mem_write_req_i = wr;
    size_i = sz; unsigned_i = uns; address_i = addr; store_data_i = wdata;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, uns, addr, 32'h0);
    @(negedge clk);
    check_eq({tag, "_data"}, load_data_o, exp);
    check_eq({tag, "_ctl"}, {28'h0, done_o, mem_read_o, mem_write_o, stall_o}, 32'hC);
    @(posedge clk); #1;
  endtask

  task automatic do_store_word(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    drive(1'b0, 1'b1, 2'b10, 1'b0, addr, wdata);
    @(negedge clk);
    check_eq({tag, "_ctl"}, {28'h0, done_o, mem_read_o, mem_write_o, stall_o}, 32'hA);
    check_eq({tag, "_wdata"}, mem_write_data_o, wdata);
    @(posedge clk); #1;
    check_eq({tag, "_mem"}, mem[addr[5:2]], wdata);
  endtask

  task automatic do_store_sub(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_word);
    drive(1'b0, 1'b1, sz, 1'b0, addr, wdata);
    @(negedge clk);
    check_eq({tag, "_ctl1"}, {28'h0, done_o, mem_read_o, mem_write_o, stall_o}, 32'h5);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_ctl2"}, {28'h0, done_o, mem_read_o, mem_write_o, stall_o}, 32'hA);
    check_eq({tag, "_addr"}, mem_address_o, {addr[31:2], 2'b00});
    check_eq({tag, "_wdata"}, mem_write_data_o, exp_word);
    @(posedge clk); #1;
    check_eq({tag, "_mem"}, mem[addr[5:2]], exp_word);
  endtask

  task automatic do_fault(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] exp_word);
    drive(rd, wr, sz, 1'b0, addr, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq({tag, "_ctl"}, {27'h0, fault_o, done_o, mem_read_o, mem_write_o, stall_o}, 32'h10);
    @(posedge clk); #1;
    check_eq({tag, "_mem"}, mem[addr[5:2]], exp_word);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
    #2;
    check_eq("reset_outs", {mem_address_o | mem_write_data_o | load_data_o},  32'h0);
    check_eq("reset_ctl", {27'h0, fault_o, done_o, mem_read_o, mem_write_o, stall_o}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    req_valid_i = 1'b0; address_i = 32'h1001_0007;
    @(negedge clk);
    check_eq("idle_addr", mem_address_o, 32'h1001_0004);
    check_eq("idle_ctl", {27'h0, fault_o, done_o, mem_read_o, mem_write_o, stall_o}, 32'h0);
    @(posedge clk); #1;

    do_store_word("sw", 32'h1001_0004, 32'hDEAD_BEEF);
    do_load("lw", 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    do_store_sub("sb", 2'b00, 32'h1001_0005, 32'h0000_00AA, 32'hDEAD_AAEF);
    do_load("lb", 2'b00, 1'b0, 32'h1001_0005, 32'hFFFF_FFAA);
    do_load("lbu", 2'b00, 1'b1, 32'h1001_0005, 32'h0000_00AA);
    do_store_sub("sh_hi", 2'b01, 32'h1001_0006, 32'h0000_1234, 32'h1234_AAEF);
    do_load("lh_hi", 2'b01, 1'b0, 32'h1001_0006, 32'h0000_1234);
    do_store_sub("sh_lo", 2'b01, 32'h1001_0004, 32'h0000_8000, 32'h1234_8000);
    do_load("lh_lo", 2'b01, 1'b0, 32'h1001_0004, 32'hFFFF_8000);
    do_load("lhu_lo", 2'b01, 1'b1, 32'h1001_0004, 32'h0000_8000);

    do_fault("f_lw_mis", 1'b1, 1'b0, 2'b10, 32'h1001_0002, 32'h0);
    do_fault("f_sh_mis", 1'b0, 1'b1, 2'b01, 32'h1001_0003, 32'h0);
    do_fault("f_size", 1'b1, 1'b0, 2'b11, 32'h1001_0004, 32'h1234_8000);
    do_fault("f_rdwr", 1'b1, 1'b1, 2'b10, 32'h1001_0004, 32'h1234_8000);

    // Reset asserted during the MERGE cycle of a byte store.
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0008, 32'h0000_0055);
    @(negedge clk);
    check_eq("rst_sb_stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("rst_mid_outs", mem_address_o | mem_write_data_o | load_data_o, 32'h0);
    check_eq("rst_mid_ctl", {27'h0, fault_o, done_o, mem_read_o, mem_write_o, stall_o}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid_i = 1'b0;
    check_eq("rst_mid_mem", mem[2], 32'h0);
    do_load("rst_lw", 2'b10, 1'b0, 32'h1001_0008, 32'h0);

    do_store_sub("b2b_sb", 2'b00, 32'h1001_000B, 32'h0000_0077, 32'h7700_0000);
    do_load("b2b_lbu", 2'b00, 1'b1, 32'h1001_000B, 32'h0000_0077);

    req_valid_i = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage controller for the MIPS datapath, placed between the EX/MEM pipeline register and the word-addressed data memory. Converts lw/lh/lhu/lb/lbu/sw/sh/sb requests into word-aligned memory transactions. Performs sub-word stores as a two-cycle read-modify-write, stalling the pipeline for one cycle. Sign/zero-extends sub-word loads and flags illegal accesses.

## Interface
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  a memory operation is present in MEM this cycle.
- mem_read_req_i  in  1  operation is a load.
- mem_write_req_i  in  1  operation is a store.
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_i  in  1  1 = zero-extend the load (lbu/lhu); 0 = sign-extend.
- address_i  in  32  full byte address from the ALU.
- store_data_i  in  32  rt value; the low byte or halfword is used for sb/sh.
- mem_read_data_i  in  32  combinational read data from the data memory.
- mem_address_o  out  32  word-aligned address to the memory, {addr[31:2],2'b00}.
- mem_write_data_o  out  32  full word to write.
- mem_write_o  out  1  memory write enable; the memory samples it on the rising edge.
- mem_read_o  out  1  memory read enable.
- load_data_o  out  32  extended load result, valid when done_o=1 for a load, else 0.
- done_o  out  1  one-cycle pulse when the operation completes.
- fault_o  out  1  one-cycle pulse for an illegal request.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - MERGE: write phase of a sub-word store; registers old_q, mask_q, wdata_q and addr_q.
- Byte order is little-endian.
  - Byte k = bits [8k+7:8k], selected by addr[1:0].
  - Halfword selected by addr[1]: 0 = bits [15:0], 1 = bits [31:16].
- fault conditions, evaluated in IDLE with req_valid_i=1:
  - size_i=11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - read and write both requested
- On fault: fault_o=1, done_o=0, no mem_read_o or mem_write_o, state stays IDLE.
- Load (IDLE): mem_read_o=1 and done_o=1 in the same cycle.
  - load_data_o is the selected lane extracted from mem_read_data_i, extended per unsigned_i.
  - stall_o=0.
- Word store (IDLE): mem_write_o=1, mem_write_data_o=store_data_i, done_o=1, stall_o=0.
- Sub-word store:
  - In IDLE: mem_read_o=1, stall_o=1, done_o=0.
  - Capture old_q←mem_read_data_i, mask_q (0x000000FF<<8·addr[1:0] for byte, 0x0000FFFF<<16·addr[1] for halfword), wdata_q←lane data shifted into position, addr_q←aligned address. Go to MERGE.
  - In MERGE: mem_address_o=addr_q, mem_write_data_o=(old_q & ~mask_q)|(wdata_q & mask_q), mem_write_o=1, done_o=1, stall_o=0. Return to IDLE.
- In MERGE all request inputs are ignored. Upstream holds them stable because of the stall.
- req_valid_i=0 in IDLE: all strobes 0, mem_address_o=aligned address_i.

## Timing
- Reset: asynchronous to IDLE. old_q, mask_q, wdata_q and addr_q clear to 0.
  - All outputs are 0 while reset is low.
  - Reset during MERGE aborts the store: no write, memory unchanged.
- Latency:
  - Loads, word stores and faults: 1 cycle (combinational outputs in the request cycle).
  - Sub-word stores: 2 cycles, exactly 1 stall cycle.
- stall_o is combinational. It is high only in the IDLE cycle that accepts a sub-word store.
- Back-to-back: a request arriving in the cycle after MERGE is accepted immediately. A load to the same word sees the merged data, because the write commits at the MERGE edge.
- All sub-word merge arithmetic uses 32-bit masks; no carries.

## Test plan
- Word round trip: sw 0xDEADBEEF @0x10010004, then lw @0x10010004 -> done_o pulses once per op, stall_o stays 0, load_data_o=0xDEADBEEF.
- Byte store and loads, word initially 0xDEADBEEF: sb 0x000000AA @0x10010005 -> stall_o high 1 cycle, mem_write_o in MERGE, word=0xDEADAAEF. Then:
  - lb @0x10010005 -> 0xFFFFFFAA
  - lbu @0x10010005 -> 0x000000AA
- Halfword store and loads:
  - sh 0x1234 @0x10010006 -> word=0x1234AAEF; lh @0x10010006 -> 0x00001234.
  - sh 0x8000 @0x10010004 -> word=0x12348000; lh @0x10010004 -> 0xFFFF8000; lhu @0x10010004 -> 0x00008000.
- Faults, each producing fault_o=1 for one cycle, done_o=0, mem_write_o never 1, memory unchanged:
  - lw @0x10010002
  - sh @0x10010003
  - size_i=11
  - read+write both set
- Reset mid-op: sb 0x55 @0x10010008 (word 0x00000000), reset low during MERGE -> no write, all outputs 0, word stays 0x00000000. After release, the next lw returns 0x00000000.
- Back-to-back: sb 0x77 @0x1001000B immediately followed by lbu @0x1001000B -> lbu completes the cycle after MERGE and returns 0x00000077.
